// File: rtl/misr_signature_analyzer.sv
// BIST response compactor: folds ALU results into a Galois-form MISR and checks the final signature.
// Optional stall watchdog enabled by defining MISR_TIMEOUT_EN (adds TIMEOUT_CYCLES and the timeout port).
module misr_signature_analyzer #(
    parameter int               WIDTH         = 8,
    parameter int               PATTERN_COUNT = 256,
    parameter logic [WIDTH-1:0] POLY          = 8'h1D,
    parameter logic [WIDTH-1:0] SEED          = 8'h00,
    parameter int               CNT_W         = $clog2(PATTERN_COUNT + 1)
`ifdef MISR_TIMEOUT_EN
    ,
    parameter int               TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] golden_sig,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef MISR_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] misr_next;
    logic             start_ok;

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy     = (state == ST_RUN) || (state == ST_CHECK);

    // Galois step: shift left, fold the dropped MSB back through POLY, then mix in the new result.
    always_comb begin
        shifted = {signature[WIDTH-2:0], 1'b0};
        if (signature[WIDTH-1]) begin
            shifted = shifted ^ POLY;
        end
        misr_next = shifted ^ alu_result;
    end

`ifdef MISR_TIMEOUT_EN
    localparam int                 STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_expire;

    assign stall_expire = (state == ST_RUN) && !result_valid && (stall_cnt == STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (start_ok) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (state == ST_RUN) begin
            if (result_valid) begin
                stall_cnt <= '0;
            end else if (stall_expire) begin
                stall_cnt <= '0;
                timeout   <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            signature   <= SEED;
            pattern_cnt <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        signature   <= SEED;
                        pattern_cnt <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (result_valid) begin
                        signature   <= misr_next;
                        pattern_cnt <= pattern_cnt + CNT_W'(1);
                        if (pattern_cnt == LAST_CNT) begin
                            state <= ST_CHECK;
                        end
                    end
`ifdef MISR_TIMEOUT_EN
                    else if (stall_expire) begin
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= ST_DONE;
                    end
`endif
                end
                ST_CHECK: begin
                    pass  <= (signature == golden_sig);
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
